// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci LFSR pattern stage and its far-end checker.
// Both sides take their feedback tap from tap_idx() so the two cannot drift apart.
package lfsr_pkg;

   typedef enum logic [1:0] {
      ACQ,
      TRACK,
      LOCKED
   } chk_state_t;

   // Feedback is d[n-1] ^ d[tap], i.e. x^n + x^(tap+1) + 1; width 8 has no maximal trinomial.
   function automatic int tap_idx(int n);
      case (n)
         3:       return 1;
         4:       return 2;
         5:       return 2;
         6:       return 4;
         7:       return 5;
         8:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic logic [7:0] lfsr_next(logic [7:0] d, int n);
      logic [7:0] r;
      r = '0;
      for (int i = 1; i < 8; i++) begin
         if (i < n) r[i] = d[i-1];
      end
      r[0] = d[n-1] ^ d[tap_idx(n)];
      return r;
   endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-word function of the Fibonacci LFSR.
// The upstream stage instantiates the same block.
module lfsr_predict
   import lfsr_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   localparam int TAP = tap_idx(N);

   assign q = {d[N-2:0], d[N-1] ^ d[TAP]};

endmodule

// File: rtl/lfsr_checker.sv
// Far-end LFSR stream checker: self-synchronises to the incoming words, counts
// mispredictions while locked and measures the sequence period.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int N        = 4,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_flag,
   output logic [ERR_W-1:0] err_count,
   output logic [N-1:0]     period,
   output logic             period_vld
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int SW = $clog2(LOSS_CNT + 1);
   localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
   localparam logic [SW-1:0]    MISS_LAST  = SW'(LOSS_CNT - 1);
   localparam logic [N-1:0]     PER_MAX    = '1;
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   chk_state_t       state_q, state_d;
   logic [N-1:0]     prev_q, prev_d;
   logic [N-1:0]     ref_word_q, ref_word_d;
   logic [MW-1:0]    match_q, match_d;
   logic [SW-1:0]    miss_q, miss_d;
   logic [N-1:0]     per_q, per_d;
   logic [ERR_W-1:0] err_cnt_d;
   logic             err_flag_d;
   logic [N-1:0]     period_d;
   logic             pvld_d;
   logic             locked_d;
   logic [N-1:0]     pred;
   logic             is_match;

   lfsr_predict #(.N(N)) u_predict (
      .d (prev_q),
      .q (pred)
   );

   assign is_match = (in_data == pred);

   // State register and all output/datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ACQ;
         prev_q     <= '0;
         ref_word_q <= '0;
         match_q    <= '0;
         miss_q     <= '0;
         per_q      <= '0;
         err_count  <= '0;
         err_flag   <= 1'b0;
         period     <= '0;
         period_vld <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         ref_word_q <= ref_word_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         per_q      <= per_d;
         err_count  <= err_cnt_d;
         err_flag   <= err_flag_d;
         period     <= period_d;
         period_vld <= pvld_d;
         locked     <= locked_d;
      end
   end

   // Next-state and next-value logic; invalid cycles leave everything but the clear untouched
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      ref_word_d = ref_word_q;
      match_d    = match_q;
      miss_d     = miss_q;
      per_d      = per_q;
      err_cnt_d  = err_count;
      err_flag_d = err_flag;
      period_d   = period;
      pvld_d     = 1'b0;

      if (in_valid) begin
         case (state_q)
            ACQ: begin
               // All-zero is the LFSR lock-up word and carries no sequence information
               if (in_data != '0) begin
                  prev_d  = in_data;
                  match_d = '0;
                  state_d = TRACK;
               end
            end

            TRACK: begin
               prev_d = in_data;
               if (is_match) begin
                  if (match_q == MATCH_LAST) begin
                     state_d    = LOCKED;
                     ref_word_d = in_data;
                     per_d      = '0;
                     miss_d     = '0;
                     match_d    = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
                  if (in_data == '0) state_d = ACQ;
               end
            end

            LOCKED: begin
               prev_d = in_data;
               per_d  = (per_q == PER_MAX) ? PER_MAX : per_q + 1'b1;
               if (is_match) begin
                  miss_d = '0;
                  // A saturated count means the period is longer than the counter can express
                  if (in_data == ref_word_q) begin
                     if (per_q != PER_MAX) begin
                        period_d = per_q + 1'b1;
                        pvld_d   = 1'b1;
                     end
                     per_d = '0;
                  end
               end else begin
                  err_flag_d = 1'b1;
                  if (err_count != ERR_MAX) err_cnt_d = err_count + 1'b1;
                  if (miss_q == MISS_LAST) begin
                     state_d = ACQ;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end
            end

            default: state_d = ACQ;
         endcase
      end

      if (clear_cnt) begin
         err_cnt_d  = '0;
         err_flag_d = 1'b0;
      end

      locked_d = (state_d == LOCKED);
   end

endmodule
